pc_gen_btb: RTL and testbench

- Parametrised next-generation fetch PC register for the CPU front end.
- Holds the fetch PC and selects the next PC from these sources, highest priority first:
  1. execute-stage redirect
  2. stall hold
  3. branch-target-buffer (BTB) prediction
  4. sequential increment
- Contains a direct-mapped BTB with 2-bit saturating counters, trained from the execute stage.
- Sits between the fetch stage (drives instruction memory address) and the execute/branch-resolution logic.

---
 rtl/pc_gen_btb.sv | 126 ++++++++++++
 tb/tb_pc_gen_btb.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/pc_gen_btb.sv
// Fetch PC register with a direct-mapped BTB of 2-bit saturating counters.
// Next PC priority: redirect, stall hold, BTB prediction, sequential increment.

module pc_gen_btb_entry #(
    parameter int TAG_W = 26,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [TAG_W-1:0] upd_tag,
    input  logic [WIDTH-1:0] upd_target,
    input  logic             upd_taken,
    output logic             valid,
    output logic [TAG_W-1:0] tag,
    output logic [WIDTH-1:0] target,
    output logic [1:0]       ctr
);
    logic hit;
    assign hit = valid && (tag == upd_tag);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid  <= 1'b0;
            tag    <= '0;
            target <= '0;
            ctr    <= 2'b01;
        end else if (we) begin
            if (hit) begin
                if (upd_taken) begin
                    if (ctr != 2'b11) ctr <= ctr + 2'd1;
                    target <= upd_target;
                end else if (ctr != 2'b00) begin
                    ctr <= ctr - 2'd1;
                end
            end else if (upd_taken) begin
                // miss on a taken branch: replace whatever aliased here
                valid  <= 1'b1;
                tag    <= upd_tag;
                target <= upd_target;
                ctr    <= 2'b10;
            end
        end
    end
endmodule

module pc_gen_btb #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int               INC      = 4,
    parameter int               IDX_W    = 4,
    parameter int               IDX_LSB  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    input  logic             upd_valid,
    input  logic [WIDTH-1:0] upd_pc,
    input  logic [WIDTH-1:0] upd_target,
    input  logic             upd_taken,
    output logic [WIDTH-1:0] pc,
    output logic             pred_taken,
    output logic [WIDTH-1:0] pred_target
);
    localparam int ENTRIES = 1 << IDX_W;
    localparam int TAG_W   = WIDTH - IDX_LSB - IDX_W;

    logic [ENTRIES-1:0]            ent_valid;
    logic [ENTRIES-1:0][TAG_W-1:0] ent_tag;
    logic [ENTRIES-1:0][WIDTH-1:0] ent_target;
    logic [ENTRIES-1:0][1:0]       ent_ctr;

    logic [IDX_W-1:0] rd_idx, upd_idx;
    logic [TAG_W-1:0] rd_tag, upd_tag;
    logic             hit;
    logic [WIDTH-1:0] pc_nxt;

    assign rd_idx  = pc[IDX_LSB +: IDX_W];
    assign rd_tag  = pc[WIDTH-1 -: TAG_W];
    assign upd_idx = upd_pc[IDX_LSB +: IDX_W];
    assign upd_tag = upd_pc[WIDTH-1 -: TAG_W];

    generate
        if (IDX_LSB > 0) begin : g_unused
            logic unused_upd_lsb;
            assign unused_upd_lsb = ^upd_pc[IDX_LSB-1:0];
        end
    endgenerate

    genvar i;
    generate
        for (i = 0; i < ENTRIES; i++) begin : g_ent
            pc_gen_btb_entry #(.TAG_W(TAG_W), .WIDTH(WIDTH)) u_ent (
                .clk        (clk),
                .reset      (reset),
                .we         (upd_valid && (upd_idx == IDX_W'(i))),
                .upd_tag    (upd_tag),
                .upd_target (upd_target),
                .upd_taken  (upd_taken),
                .valid      (ent_valid[i]),
                .tag        (ent_tag[i]),
                .target     (ent_target[i]),
                .ctr        (ent_ctr[i])
            );
        end
    endgenerate

    // Reads see pre-edge contents, so a same-index update lands next cycle.
    assign hit         = ent_valid[rd_idx] && (ent_tag[rd_idx] == rd_tag);
    assign pred_taken  = hit && ent_ctr[rd_idx][1];
    assign pred_target = hit ? ent_target[rd_idx] : '0;

    always_comb begin
        pc_nxt = pc + WIDTH'(INC);
        if (redirect_valid)  pc_nxt = redirect_pc;
        else if (stall)      pc_nxt = pc;
        else if (pred_taken) pc_nxt = pred_target;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) pc <= RESET_PC;
        else       pc <= pc_nxt;
    end
endmodule

// File: tb/tb_pc_gen_btb.sv
// Directed table-driven bench for pc_gen_btb plus hand sequences for reset and wrap.

module tb_pc_gen_btb;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0, redirect_valid = 1'b0, upd_valid = 1'b0, upd_taken = 1'b0;
    logic [31:0] redirect_pc = '0, upd_pc = '0, upd_target = '0;
    logic [31:0] pc, pred_target;
    logic        pred_taken;

    logic        wstall = 1'b1;
    logic [7:0]  wpc, wpred_target;
    logic        wpred_taken;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pc_gen_btb #(.WIDTH(32), .RESET_PC(32'h100)) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken),
        .pc(pc), .pred_taken(pred_taken), .pred_target(pred_target)
    );

    pc_gen_btb #(.WIDTH(8), .RESET_PC(8'hFC)) dut_w (
        .clk(clk), .reset(reset), .stall(wstall),
        .redirect_valid(1'b0), .redirect_pc(8'h00),
        .upd_valid(1'b0), .upd_pc(8'h00), .upd_target(8'h00), .upd_taken(1'b0),
        .pc(wpc), .pred_taken(wpred_taken), .pred_target(wpred_target)
    );

    typedef struct {
        logic        st;
        logic        rv;
        logic [31:0] rpc;
        logic        uv;
        logic [31:0] upc;
        logic [31:0] utgt;
        logic        ut;
        logic [31:0] epc;
        logic        ept;
        logic [31:0] etgt;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs [NV];

    function automatic vec_t mk(logic st, logic rv, logic [31:0] rpc, logic uv, logic [31:0] upc,
                                logic [31:0] utgt, logic ut, logic [31:0] epc, logic ept,
                                logic [31:0] etgt);
        vec_t v;
        v.st = st; v.rv = rv; v.rpc = rpc; v.uv = uv; v.upc = upc;
        v.utgt = utgt; v.ut = ut; v.epc = epc; v.ept = ept; v.etgt = etgt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [31:0] epc, input logic ept,
                             input logic [31:0] etgt);
        chk({tag, " pc"}, pc, epc);
        chk({tag, " pred_taken"}, {31'd0, pred_taken}, {31'd0, ept});
        chk({tag, " pred_target"}, pred_target, etgt);
    endtask

    initial begin
        //             st rv rpc      uv upc      utgt     ut  epc      ept etgt
        vecs[0]  = mk(0, 0, 32'h0,   0, 32'h0,   32'h0,   0, 32'h104, 0, 32'h0);
        vecs[1]  = mk(0, 0, 32'h0,   0, 32'h0,   32'h0,   0, 32'h108, 0, 32'h0);
        vecs[2]  = mk(1, 0, 32'h0,   0, 32'h0,   32'h0,   0, 32'h108, 0, 32'h0);
        vecs[3]  = mk(1, 0, 32'h0,   0, 32'h0,   32'h0,   0, 32'h108, 0, 32'h0);
        vecs[4]  = mk(0, 0, 32'h0,   0, 32'h0,   32'h0,   0, 32'h10C, 0, 32'h0);
        vecs[5]  = mk(0, 1, 32'h200, 0, 32'h0,   32'h0,   0, 32'h200, 0, 32'h0);
        vecs[6]  = mk(1, 1, 32'h40,  0, 32'h0,   32'h0,   0, 32'h40,  0, 32'h0);
        // train while sitting on 40: this cycle still uses old contents -> 44
        vecs[7]  = mk(0, 0, 32'h0,   1, 32'h40,  32'h80,  1, 32'h44,  0, 32'h0);
        vecs[8]  = mk(0, 1, 32'h40,  0, 32'h0,   32'h0,   0, 32'h40,  1, 32'h80);
        vecs[9]  = mk(0, 0, 32'h0,   0, 32'h0,   32'h0,   0, 32'h80,  0, 32'h0);
        vecs[10] = mk(0, 1, 32'h40,  1, 32'h40,  32'h80,  1, 32'h40,  1, 32'h80);
        vecs[11] = mk(1, 0, 32'h0,   1, 32'h40,  32'h80,  1, 32'h40,  1, 32'h80);
        // not-taken: 11->10->01->00->00, target never overwritten
        vecs[12] = mk(1, 0, 32'h0,   1, 32'h40,  32'h999, 0, 32'h40,  1, 32'h80);
        vecs[13] = mk(1, 0, 32'h0,   1, 32'h40,  32'h999, 0, 32'h40,  0, 32'h80);
        vecs[14] = mk(1, 0, 32'h0,   1, 32'h40,  32'h999, 0, 32'h40,  0, 32'h80);
        vecs[15] = mk(1, 0, 32'h0,   1, 32'h40,  32'h999, 0, 32'h40,  0, 32'h80);
        vecs[16] = mk(1, 0, 32'h0,   1, 32'h40,  32'h80,  1, 32'h40,  0, 32'h80);
        vecs[17] = mk(1, 0, 32'h0,   1, 32'h40,  32'h80,  1, 32'h40,  1, 32'h80);
        // alias 440 onto index 0, evicting 40
        vecs[18] = mk(1, 0, 32'h0,   1, 32'h440, 32'h900, 1, 32'h40,  0, 32'h0);
        vecs[19] = mk(0, 1, 32'h440, 0, 32'h0,   32'h0,   0, 32'h440, 1, 32'h900);
        vecs[20] = mk(0, 0, 32'h0,   0, 32'h0,   32'h0,   0, 32'h900, 0, 32'h0);
        vecs[21] = mk(1, 0, 32'h0,   1, 32'h900, 32'h123, 0, 32'h900, 0, 32'h0);
        vecs[22] = mk(0, 1, 32'h440, 0, 32'h0,   32'h0,   0, 32'h440, 1, 32'h900);

        @(negedge clk);
        @(negedge clk);
        check_out("reset", 32'h100, 1'b0, 32'h0);
        chk("reset wrap pc", {24'd0, wpc}, 32'h0000_00FC);
        reset = 1'b0;

        for (int k = 0; k < NV; k++) begin
            stall = vecs[k].st; redirect_valid = vecs[k].rv; redirect_pc = vecs[k].rpc;
            upd_valid = vecs[k].uv; upd_pc = vecs[k].upc; upd_target = vecs[k].utgt;
            upd_taken = vecs[k].ut;
            @(posedge clk);
            #1;
            check_out($sformatf("vec%0d", k), vecs[k].epc, vecs[k].ept, vecs[k].etgt);
            @(negedge clk);
        end
        stall = 1'b0; redirect_valid = 1'b0; upd_valid = 1'b0; upd_taken = 1'b0;

        // asynchronous reset mid-cycle clears pc and BTB at once
        #2 reset = 1'b1;
        #1 check_out("async reset", 32'h100, 1'b0, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h440;
        @(posedge clk);
        #1 check_out("post-reset 440", 32'h440, 1'b0, 32'h0);
        @(negedge clk);
        redirect_pc = 32'h40;
        @(posedge clk);
        #1 check_out("post-reset 40", 32'h40, 1'b0, 32'h0);
        @(negedge clk);
        redirect_valid = 1'b0;

        // 8-bit instance was held at FC since reset; one step must wrap to 00
        wstall = 1'b0;
        @(posedge clk);
        #1;
        chk("wrap pc", {24'd0, wpc}, 32'h0);
        chk("wrap pred_taken", {31'd0, wpred_taken}, 32'h0);
        @(negedge clk);
        wstall = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
